// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared constants and FSM state type for serial_adder
//
// Purpose : FSM state encoding and default operand width used by serial_adder.
// Contents: ST_IDLE/ST_RUN/ST_DONE encodings, SA_WIDTH_DEF, sa_state_e enum.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } sa_state_e;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational one-bit full adder cell
//
// Purpose : single full-adder cell shared by every bit step of serial_adder.
// Ports   : a, b, c  (in)  operand bits and carry in
//           sum      (out) a ^ b ^ c
//           carry    (out) majority(a, b, c)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder sequencing one fa_cell LSB to MSB
//
// Purpose : computes {cout, sum} = a + b + cin over WIDTH clock cycles using a
//           single full-adder cell with a registered carry.
// Ports   : clk, rst_n (async active-low)
//           start (in)  request, sampled only in IDLE
//           a, b  (in)  WIDTH-bit operands, cin (in) carry in
//           busy  (out) high while running
//           done  (out) one-cycle pulse on a new result
//           sum   (out) WIDTH-bit registered result, cout (out) final carry
//           ovf   (out) signed overflow, present only with SERIAL_ADDER_OVF_EN
// Config  : define SERIAL_ADDER_OVF_EN to add the ovf output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must be at least one bit wide even when WIDTH is 1.
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_e        state;
  sa_state_e        state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_nxt;
  logic             c_r;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             co_bit;
  logic             last_step;

  fa_cell u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (c_r),
    .sum   (s_bit),
    .carry (co_bit)
  );

  assign last_step = (cnt == CNT_LAST);

  // New sum bit enters at the MSB; after WIDTH steps the first bit reaches bit 0.
  always_comb begin
    s_nxt            = s_sr >> 1;
    s_nxt[WIDTH-1]   = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      c_r  <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            c_r  <= cin;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          s_sr <= s_nxt;
          c_r  <= co_bit;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            sum  <= s_nxt;
            cout <= co_bit;
`ifdef SERIAL_ADDER_OVF_EN
            // c_r is the carry into the MSB step on the final edge.
            ovf  <= c_r ^ co_bit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard testbench for serial_adder (WIDTH 8 and 1)
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         start1, a1, b1, cin1;
  logic         busy1, done1, sum1, cout1;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf, ovf1;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q8[$];
  exp_t q1[$];
  logic [W-1:0] last_s;
  logic         last_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(W)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer addition; overflow when operands share a sign the result lacks.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input int t);
    exp_t        e;
    logic [32:0] tot;
    logic [32:0] mask;
    logic        sa, sb, ss;
    tot  = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    mask = (33'd1 << w) - 33'd1;
    sa   = av[w-1];
    sb   = bv[w-1];
    ss   = tot[w-1];
    e.s  = W'(tot & mask);
    e.c  = tot[w];
    e.v  = (sa == sb) && (ss != sa);
    e.t  = t;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q8.size() == 0) begin
        check("w8_spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_sum", 32'(sum), 32'(e.s));
        check("w8_cout", 32'(cout), 32'(e.c));
        check("w8_done_cycle", 32'(cyc), 32'(e.t));
`ifdef SERIAL_ADDER_OVF_EN
        check("w8_ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("w1_spurious_done", 32'(done1), 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("w1_sum", 32'(sum1), 32'(e.s[0]));
        check("w1_cout", 32'(cout1), 32'(e.c));
        check("w1_done_cycle", 32'(cyc), 32'(e.t));
`ifdef SERIAL_ADDER_OVF_EN
        check("w1_ovf", 32'(ovf1), 32'(e.v));
`endif
      end
    end
  end

  // One WIDTH-8 operation; optional stray starts at RUN cycle 3 and at the DONE edge.
  task automatic op8(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input bit inj);
    exp_t e;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk);
    #1;
    e = model(W, 32'(av), 32'(bv), cv, cyc + W);
    q8.push_back(e);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (inj && (k == 3 || k == W + 1)) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k == 1) check("busy_after_accept", 32'(busy), 32'd1);
      if (k <= W) check("sum_hold_run", 32'({cout, sum}), 32'({last_c, last_s}));
      @(posedge clk);
    end
    #1 start = 1'b0;
    last_s = e.s;
    last_c = e.c;
  endtask

  task automatic op1(input logic av, input logic bv, input logic cv);
    exp_t e;
    @(negedge clk);
    start1 = 1'b1; a1 = av; b1 = bv; cin1 = cv;
    @(posedge clk);
    #1;
    e = model(1, 32'(av), 32'(bv), cv, cyc + 1);
    q1.push_back(e);
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    last_s = '0; last_c = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    op8(8'h0F, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h55, 8'h2A, 1'b1, 1'b1);
    op8(8'h80, 8'h80, 1'b0, 1'b0);

    // Abort mid-RUN: outputs must clear immediately and the op is discarded.
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h3C; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_sum", 32'(sum), 32'd0);
    check("midrun_rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("midrun_rst_ovf", 32'(ovf), 32'd0);
`endif
    last_s = '0; last_c = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    op8(8'h12, 8'h34, 1'b0, 1'b0);
    check("after_rst_sum_46", 32'(sum), 32'h46);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    for (int i = 0; i < 20; i++) begin
      op8(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("w8_queue_drained", 32'(q8.size()), 32'd0);
    check("w1_queue_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
